// File: rtl/parity_pkg.sv
// parity_pkg: shared types and constants for the parity_frame block.
//   state_t : FSM state encoding (ACC = accumulating bits, OUT = result presented)
//   CNT_W   : width of the bit counter and the frame counter
package parity_pkg;

  localparam int CNT_W = 8;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

endpackage

// File: rtl/xor1.sv
// xor1: single two-input XOR gate.
//   a, b : inputs
//   c    : a ^ b
module xor1 (
  input  logic a,
  input  logic b,
  output logic c
);

  assign c = a ^ b;

endmodule

// File: rtl/parity_frame.sv
// parity_frame: serial framer computing even (XOR) parity over FRAME_LEN data bits.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : in_bit carries a valid serial bit
//   in_ready   : block accepts in_bit this cycle (high only in ACC)
//   in_bit     : serial data bit
//   out_valid  : frame result presented (high only in OUT)
//   out_ready  : downstream takes the result
//   out_parity : XOR of the frame's data bits
//   frame_cnt  : number of results taken by downstream, wraps 255 -> 0
//   parity_err : received parity mismatch, meaningful while out_valid=1
//
// Build option
//   PARITY_CHECK_EN : when defined, each frame carries one extra received parity
//                     bit after the data; it is compared against the computed
//                     parity instead of being accumulated. When undefined,
//                     parity_err is tied to 0.
//
// state | meaning
// ACC   | accepting serial bits, in_ready=1
// OUT   | result held until out_ready, in_ready=0
module parity_frame
  import parity_pkg::*;
#(
  parameter int FRAME_LEN = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             parity_err
);

`ifdef PARITY_CHECK_EN
  localparam int FRAME_BITS = FRAME_LEN + 1;
`else
  localparam int FRAME_BITS = FRAME_LEN;
`endif
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BITS - 1);

  state_t           state;
  state_t           state_nxt;
  logic             acc;
  logic             acc_nxt;
  logic             accept;
  logic             last;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] frame_cnt_q;
  logic             parity_q;

  xor1 u_xor (
    .a (acc),
    .b (in_bit),
    .c (acc_nxt)
  );

  assign accept = in_valid & in_ready;
  assign last   = (bit_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) state <= ACC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (accept && last) state_nxt = OUT;
      OUT:     if (out_ready)      state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACC:     in_ready  = 1'b1;
      OUT:     out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

`ifdef PARITY_CHECK_EN
  logic err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= 1'b0;
      bit_cnt     <= '0;
      frame_cnt_q <= '0;
      parity_q    <= 1'b0;
`ifdef PARITY_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else if (state == OUT) begin
      if (out_ready) begin
        acc         <= 1'b0;
        bit_cnt     <= '0;
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end else if (accept) begin
      bit_cnt <= bit_cnt + 1'b1;
`ifdef PARITY_CHECK_EN
      // last accepted bit is the received parity: compare, do not accumulate
      if (last) begin
        parity_q <= acc;
        err_q    <= in_bit ^ acc;
      end else begin
        acc <= acc_nxt;
      end
`else
      acc <= acc_nxt;
      if (last) parity_q <= acc_nxt;
`endif
    end
  end

  assign out_parity = parity_q;
  assign frame_cnt  = frame_cnt_q;
`ifdef PARITY_CHECK_EN
  assign parity_err = err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_parity_frame.sv
// tb_parity_frame: randomized + directed bench for parity_frame with a
// scoreboard. The driver pushes the expected result of each frame (parity from
// a ones-count model, parity error, edge of the last accept); the monitor pops
// on each rising out_valid, checks hold stability, frame_cnt and in_ready, and
// plays the downstream by driving out_ready.
module tb_parity_frame;

  localparam int FL = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic       out_parity;
  logic       parity_err;
  logic [7:0] frame_cnt;

  parity_frame #(.FRAME_LEN(FL)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bit     (in_bit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_parity (out_parity),
    .frame_cnt  (frame_cnt),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic par;
    logic err;
    int   edge_n;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   last_edge = 0;
  int   hold_next = 0;

  function automatic void check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  // ---------------- monitor / downstream ----------------
  logic [7:0] exp_fc = 8'd0;
  logic       in_out = 1'b0;
  logic       lat_par, lat_err;
  int         hold = 0;
  exp_t       e;

  always @(negedge clk) begin
    if (rst) begin
      exp_fc    = 8'd0;
      in_out    = 1'b0;
      hold      = 0;
      out_ready = 1'b0;
      sb.delete();
    end else begin
      check("frame_cnt", int'(frame_cnt), int'(exp_fc));
      check("in_ready_vs_out_valid", int'(in_ready), int'(!out_valid));
      if (out_valid && !in_out) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got out_valid=1 expected no pending frame");
        end else begin
          e = sb.pop_front();
          check("out_parity", int'(out_parity), int'(e.par));
          check("parity_err", int'(parity_err), int'(e.err));
          check("latency_edge", cyc, e.edge_n);
        end
        lat_par = out_parity;
        lat_err = parity_err;
        in_out  = 1'b1;
        hold    = hold_next;
      end else if (out_valid) begin
        check("hold_out_parity", int'(out_parity), int'(lat_par));
        check("hold_parity_err", int'(parity_err), int'(lat_err));
      end else begin
        in_out = 1'b0;
      end
      if (out_valid) begin
        if (hold > 0) begin
          out_ready = 1'b0;
          hold--;
        end else begin
          out_ready = 1'b1;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      if (out_valid && out_ready) exp_fc++;
    end
  end

  // ---------------- driver ----------------
  // Called and returns at posedge+#1.
  task automatic send_bit(input logic b, input int gap);
    int t = 0;
    in_valid = 1'b0;
    repeat (gap) begin
      in_bit = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_bit   = b;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 for 200 cycles expected 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    last_edge = cyc;
    in_valid  = 1'b0;
  endtask

  task automatic send_frame(input logic [FL-1:0] d, input int gap, input logic rxp,
                            input int hold_cycles);
    exp_t x;
    hold_next = hold_cycles;
    for (int i = 0; i < FL; i++) send_bit(d[i], gap);
    x.par = 1'($countones(d) % 2);
`ifdef PARITY_CHECK_EN
    send_bit(rxp, gap);
    x.err = (rxp != x.par);
`else
    x.err = rxp & 1'b0;
`endif
    x.edge_n = last_edge;
    sb.push_back(x);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_frame_cnt", int'(frame_cnt), 0);
    check("rst_out_parity", int'(out_parity), 0);
    check("rst_parity_err", int'(parity_err), 0);

    // bits 1,0,1,1,0,0,0,0 back-to-back, held 5 cycles in OUT
    send_frame(8'b0000_1101, 0, 1'b1, 5);
    wait_idle();
    check("frame_cnt_after_first", int'(frame_cnt), 1);

    // all ones with a bubble before every bit
    send_frame(8'hFF, 1, 1'b0, 1);
    wait_idle();

    // reset after 4 accepted bits discards the partial frame
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    do_reset();
    check("midframe_rst_out_valid", int'(out_valid), 0);
    check("midframe_rst_frame_cnt", int'(frame_cnt), 0);
    send_frame(8'h01, 0, 1'b0, 0);
    wait_idle();

`ifdef PARITY_CHECK_EN
    send_frame(8'b0000_0111, 0, 1'b0, 2);
    send_frame(8'b0000_0111, 0, 1'b1, 0);
    wait_idle();
`endif

    // randomized frames, bubbles and backpressure
    for (int n = 0; n < 40; n++)
      send_frame(FL'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3));
    wait_idle();

    // reset while a result is pending in OUT
    send_frame(FL'($urandom), 0, 1'($urandom_range(0, 1)), 10);
    repeat (2) @(posedge clk);
    #1;
    check("out_pending_before_rst", int'(out_valid), 1);
    do_reset();
    check("out_rst_out_valid", int'(out_valid), 0);
    check("out_rst_frame_cnt", int'(frame_cnt), 0);

    // 256 frames from zero wrap frame_cnt back to 0
    for (int n = 0; n < 256; n++)
      send_frame(FL'($urandom), 0, 1'($urandom_range(0, 1)), 0);
    wait_idle();
    check("frame_cnt_wrap", int'(frame_cnt), 0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    checks++;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/parity_frame.md
PARITY_FRAME -- requirements
Module: parity_frame

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter FRAME_LEN SHALL default to 8 and SHALL set the number of data bits per frame; legal range is 2..255.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous active-high reset.
REQ-005 Port in_valid, input, 1 bit: in_bit carries a valid serial bit.
REQ-006 Port in_ready, output, 1 bit: the block accepts in_bit this cycle.
REQ-007 Port in_bit, input, 1 bit: serial data bit.
REQ-008 Port out_valid, output, 1 bit: a frame result is presented.
REQ-009 Port out_ready, input, 1 bit: downstream takes the result.
REQ-010 Port out_parity, output, 1 bit: even parity (XOR) of the frame's data bits.
REQ-011 Port frame_cnt, output, 8 bits: count of results taken by downstream.
REQ-012 Port parity_err, output, 1 bit: received parity mismatch; meaningful only while out_valid=1.

Function
REQ-013 An input bit SHALL be accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-014 The FSM SHALL have two states:
- ACC: in_ready=1, out_valid=0.
- OUT: in_ready=0, out_valid=1.
REQ-015 In ACC, each accepted bit SHALL update acc <= acc XOR in_bit and increment bit_cnt.
REQ-016 When the last bit of the frame is accepted, the block SHALL enter OUT on the next edge, with out_parity = acc XOR last bit.
- Latency: out_valid rises one cycle after the last accept.
REQ-017 In OUT with out_ready=1, the block SHALL return to ACC on the next edge.
- acc and bit_cnt cleared; frame_cnt incremented.
REQ-018 frame_cnt SHALL wrap from 255 to 0.
REQ-019 out_parity, parity_err and out_valid SHALL hold stable in OUT until out_ready=1.
REQ-020 No bypass: in the OUT cycle where out_ready=1, in_ready SHALL remain 0; the first bit of the next frame is accepted no earlier than the following cycle.
REQ-021 In ACC, in_valid=0 SHALL leave all state unchanged (bubbles allowed mid-frame).
REQ-022 out_ready SHALL be ignored in ACC.

Reset
REQ-023 While rst=1 the block SHALL, at the next edge, enter ACC with:
- acc=0, bit_cnt=0, frame_cnt=0;
- out_valid=0, out_parity=0, parity_err=0;
- in_ready=1 after reset deasserts.
REQ-024 Reset asserted mid-frame or in OUT SHALL discard the partial or pending frame without incrementing frame_cnt.
REQ-025 rst SHALL take priority over every simultaneous handshake.

Configuration
REQ-026 Macro PARITY_CHECK_EN SHALL control received-parity checking.
REQ-027 With PARITY_CHECK_EN defined:
- each frame is FRAME_LEN data bits followed by one received parity bit;
- the parity bit is not XORed into acc;
- on entering OUT, parity_err = (received bit != computed parity);
- out_valid latency is measured from acceptance of the parity bit.
REQ-028 Without PARITY_CHECK_EN, a frame SHALL be FRAME_LEN bits and parity_err SHALL be tied to 0.

Structure
REQ-029 Package parity_pkg SHALL hold:
- the FSM state enum (ACC, OUT);
- constant CNT_W=8 (bit_cnt and frame_cnt width).
REQ-030 The XOR accumulate step SHALL instantiate the existing xor1 gate (ports a, b, c) as the single sub-module; all other logic SHALL be inline.

Verification
REQ-031 Reset, then 8 bits 1,0,1,1,0,0,0,0 with in_valid held high -> out_valid=1 one cycle after the 8th accept, out_parity=1, in_ready=0.
REQ-032 Hold out_ready=0 for 5 cycles in OUT -> outputs stable, in_ready=0; then out_ready=1 -> next cycle in ACC, frame_cnt=1.
REQ-033 Frame of all-ones with in_valid toggling every other cycle -> out_parity=0; bit count correct despite bubbles.
REQ-034 Assert rst after 4 bits accepted -> out_valid=0, frame_cnt=0; a following full frame of 0x01 -> out_parity=1.
REQ-035 Run 256 frames with out_ready=1 -> frame_cnt wraps to 0.
REQ-036 PARITY_CHECK_EN: data 1,1,1,0,0,0,0,0 with parity bit 0 -> parity_err=1, out_parity=1; same data with parity bit 1 -> parity_err=0.
